// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// A grant is held until the last byte, MAX_BURST bytes, or TIMEOUT idle cycles mid-packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   grant_id_q, grant_id_d;
    logic         grant_valid_q, grant_valid_d;
    logic [2:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]  idle_cnt_q, idle_cnt_d;
    logic         last_flag_q, last_flag_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_start_q, tx_start_d;
    logic         err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]   gsel;
    logic [8*NUM_REQ-1:0] data_sh;
    logic                 g_valid;
    logic                 g_last;
    logic [7:0]           g_data;
    logic                 pick_found;
    logic [2:0]           pick_id;
    logic                 release_grant;

    // Signals of the currently granted requester
    always_comb begin
        gsel    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
        data_sh = req_data >> {grant_id_q, 3'b000};
        g_valid = |(req_valid & gsel);
        g_last  = |(req_last & gsel);
        g_data  = data_sh[7:0];
    end

    // First valid requester scanning from rr_ptr upward, wrapping at NUM_REQ
    always_comb begin : pick
        logic [3:0]         idx;
        logic [NUM_REQ-1:0] vshift;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        vshift     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            vshift = req_valid >> idx;
            if (!pick_found && vshift[0]) begin
                pick_found = 1'b1;
                pick_id    = idx[2:0];
            end
        end
    end

    assign req_ready = (state_q == S_SEND && !uart_tx_busy) ? gsel : '0;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_ptr_d      = rr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        last_flag_d   = last_flag_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;
        release_grant = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    byte_cnt_d    = '0;
                    idle_cnt_d    = '0;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                // A handshake always beats a timeout in the same cycle
                if (g_valid && !uart_tx_busy) begin
                    tx_data_d   = g_data;
                    tx_start_d  = 1'b1;
                    last_flag_d = g_last;
                    byte_cnt_d  = byte_cnt_q + 8'd1;
                    idle_cnt_d  = '0;
                    state_d     = S_WAIT_BUSY;
                end else if (!g_valid) begin
                    if (idle_cnt_q == 16'(TIMEOUT - 1)) begin
                        err_timeout_d = 1'b1;
                        release_grant = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_flag_q || byte_cnt_q == 8'(MAX_BURST)) begin
                        release_grant = 1'b1;
                    end else begin
                        idle_cnt_d = '0;
                        state_d    = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (release_grant) begin
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            rr_ptr_d      = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
            state_d       = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            last_flag_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            last_flag_q   <= last_flag_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign uart_tx_start = tx_start_q;
    assign uart_tx_data  = tx_data_q;
    assign grant_valid   = grant_valid_q;
    assign grant_id      = grant_id_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration at packet granularity.
- A winning requester holds the transmitter until it sends its last byte, reaches MAX_BURST bytes, or stalls for TIMEOUT cycles.
- Sits between the requesters (command/status/debug sources) and the UART tx_start/tx_data/tx_busy interface.
- The UART samples tx_start only when tx_busy is low and raises tx_busy on the following cycle.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_BURST, 16, maximum bytes per grant before a forced release; legal range 1..255.
- TIMEOUT, 1024, cycles of req_valid low on the granted requester mid-packet before a forced release; legal range 1..65535.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  requester i byte on bits [8i+7:8i].
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by valid.
- req_ready  output  NUM_REQ  byte accepted; at most one bit high per cycle.
- uart_tx_start  output  1  single-cycle start pulse to the UART.
- uart_tx_data  output  8  byte to the UART; stable from the start pulse until the next handshake.
- uart_tx_busy  input  1  UART transmitter busy.
- grant_valid  output  1  a requester currently holds the transmitter.
- grant_id  output  3  index of the granted requester; 0 when grant_valid is 0.
- err_timeout  output  1  one-cycle pulse on a timeout release.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: req_ready=0, uart_tx_start=0, uart_tx_data=0, grant_valid=0, grant_id=0, err_timeout=0.
  - Internal: rr_ptr=0, byte_cnt=0, idle_cnt=0; FSM to IDLE.
  - A byte already inside the UART is not the arbiter's concern.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, clear byte_cnt and idle_cnt, go to SEND. Grant is visible the next cycle.
- SEND (granted requester g):
  - req_ready[g] = (state==SEND) && !uart_tx_busy. This is combinational; all other req_ready bits are 0.
  - Handshake occurs when req_valid[g] && req_ready[g]:
    - Register uart_tx_data <= byte of g.
    - uart_tx_start <= 1 for exactly the next cycle.
    - Capture last_flag <= req_last[g], byte_cnt++, clear idle_cnt, go to WAIT_BUSY.
  - If req_valid[g] is low: idle_cnt++.
  - If idle_cnt reaches TIMEOUT-1 with req_valid[g] still low:
    - Pulse err_timeout for one cycle.
    - Release the grant: grant_valid=0, grant_id=0, rr_ptr=(g+1) mod NUM_REQ.
    - Go to IDLE.
- WAIT_BUSY:
  - uart_tx_start is high in the first cycle only.
  - Stay until uart_tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay while uart_tx_busy=1.
  - On uart_tx_busy=0, if last_flag or byte_cnt==MAX_BURST: release the grant (same as the timeout release, without err_timeout) and go to IDLE.
  - Otherwise, clear idle_cnt and return to SEND.
- Throughput: every byte spans one full UART frame; no pipelining of a second byte while busy.
- Fairness:
  - rr_ptr advances only on release, to one past the released requester.
  - A requester that is denied gains priority by rotation; no requester waits more than NUM_REQ-1 grants.
- Forced release at MAX_BURST splits the packet. The remainder is sent on a later grant and may interleave with other requesters.
- Requester bits at or above NUM_REQ are ignored.
- Simultaneous events:
  - A req_valid change on a non-granted requester has no effect mid-grant.
  - A timeout and a handshake in the same cycle: the handshake wins.
- If the granted requester drops req_valid mid-packet, the timeout counter runs; no bytes from other requesters are sent before release.

Test Plan:
- Single packet: req 1 sends 0x41,0x42,0x43 (last on 0x43), UART stub with 3-cycle busy.
  - Expect 3 start pulses with data 0x41,0x42,0x43, grant_id=1 throughout.
  - Expect release after the third busy fall, and rr_ptr=2.
- Round robin: requesters 0, 2, 3 each hold a 1-byte packet at reset release.
  - Expect grant order 0, 2, 3.
  - Then re-raise 0 and 3: expect grant order 0, 3.
- Burst cap: MAX_BURST=4, req 0 streams 6 bytes with last on byte 6 while req 1 waits.
  - Expect bytes 1–4 from req 0, then req 1's packet, then bytes 5–6 from req 0.
- Timeout: TIMEOUT=8, req 2 sends 1 byte without last, then drops valid.
  - Expect err_timeout pulse 8 cycles after entering SEND, grant_valid=0, and the next grant going to req 3 if valid.
- Busy gating: hold uart_tx_busy=1 while in SEND.
  - Expect req_ready=0 and no start pulse.
  - On busy low, expect req_ready high in the same cycle.
- Reset mid-frame: assert rst_n low during WAIT_DONE.
  - Expect all outputs 0 immediately.
  - After reset, a new request from req 3 is granted before req 0 only if req 0 is idle (rr_ptr back to 0).
